// File: rtl/logreg_pkg.sv
// ---------------------------------------------------------------------------
// logreg_pkg
// Shared sizing, state encoding and feature-index constants for the
// time-multiplexed logistic-regression scorer.
//   W        data / coefficient / accumulator width
//   NFEAT    features per vector (index 0 = bias, index 1 = forced zero)
//   NCLASS   number of coefficient sets
//   CW/FW/AW class-index, feature-index and theta-ROM address widths
// ---------------------------------------------------------------------------
package logreg_pkg;

    localparam int W      = 32;
    localparam int NFEAT  = 41;
    localparam int NCLASS = 4;
    localparam int CW     = $clog2(NCLASS);
    localparam int FW     = $clog2(NFEAT);
    localparam int AW     = $clog2(NCLASS * NFEAT);

    localparam int BIAS_IDX = 0;
    localparam int ZERO_IDX = 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        DRAIN,
        OUT
    } state_t;

endpackage

// File: rtl/logreg_mac_acc.sv
// ---------------------------------------------------------------------------
// logreg_mac_acc
// Shared MAC slice: selects the term for one feature (bias passthrough,
// forced zero, or signed product truncated to W bits) and accumulates it.
// The bias term restarts the accumulator, so no separate clear is needed
// between classes.
//   clk, rst   clock, synchronous active-high reset
//   en         a term is present this cycle
//   first      term is the bias: acc restarts at theta
//   zero       term is forced to zero
//   x, theta   feature word and coefficient
//   acc_next   value the accumulator takes at the next edge
// ---------------------------------------------------------------------------
module logreg_mac_acc
    import logreg_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         first,
    input  logic         zero,
    input  logic [W-1:0] x,
    input  logic [W-1:0] theta,
    output logic [W-1:0] acc_next
);

    logic [W-1:0] acc;
    logic [W-1:0] prod;
    logic [W-1:0] term;

    // NOTE: every variable written here gets a value on every path (defaults
    // first), otherwise synthesis infers a latch.
    always_comb begin
        // Low W bits of a two's-complement product are the same whether the
        // operands are taken as signed or unsigned; wrap mod 2^W is intended.
        prod = W'($signed(x) * $signed(theta));
        term = prod;
        if (first) begin
            term = theta;
        end else if (zero) begin
            term = '0;
        end

        acc_next = acc;
        if (en) begin
            acc_next = first ? term : acc + term;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else begin
            acc <= acc_next;
        end
    end

endmodule

// File: rtl/logreg_mac_scheduler.sv
// ---------------------------------------------------------------------------
// logreg_mac_scheduler
// Buffers one feature vector, then streams NCLASS*NFEAT theta reads through a
// single MAC and keeps a running signed argmax. Result is held until taken.
//   clk, rst            clock, synchronous active-high reset
//   x_valid/x_ready     feature stream handshake; x_data = feature n on beat n
//   x_last              final beat of a vector
//   theta_addr/rd       theta ROM request (addr = class*NFEAT + feature)
//   theta_data          ROM data, valid one cycle after theta_rd
//   res_valid/ready     result handshake; res_class/res_score = argmax
//   len_err             one-cycle pulse on malformed frame length
//   busy                any state other than IDLE
// ---------------------------------------------------------------------------
module logreg_mac_scheduler
    import logreg_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          x_valid,
    output logic          x_ready,
    input  logic [W-1:0]  x_data,
    input  logic          x_last,
    output logic [AW-1:0] theta_addr,
    output logic          theta_rd,
    input  logic [W-1:0]  theta_data,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [CW-1:0] res_class,
    output logic [W-1:0]  res_score,
    output logic          len_err,
    output logic          busy
);

    state_t state, state_next;

    logic [FW-1:0] feat_cnt;
    logic [CW-1:0] cls_cnt;
    logic [FW-1:0] len_q;       // beats in the buffered frame
    logic [W-1:0]  fbuf [NFEAT];

    logic          beat, end_beat, last_read;
    logic          len_err_q;

    // Apply-stage copies of the read issued last cycle.
    logic          rd_q;
    logic [FW-1:0] fidx_q;
    logic [CW-1:0] cls_q;
    logic [W-1:0]  x_q;

    logic [W-1:0]  acc_next;
    logic [W-1:0]  best_score;
    logic [CW-1:0] best_class;

    assign beat      = x_valid && (state == IDLE || state == LOAD);
    assign end_beat  = beat && (x_last || feat_cnt == FW'(NFEAT - 1));
    assign last_read = (state == RUN) && cls_cnt == CW'(NCLASS - 1)
                       && feat_cnt == FW'(NFEAT - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        x_ready    = 1'b0;
        theta_rd   = 1'b0;
        theta_addr = '0;
        res_valid  = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE, LOAD: begin
                x_ready = 1'b1;
                if (end_beat) begin
                    state_next = RUN;
                end else if (beat) begin
                    state_next = LOAD;
                end
            end
            RUN: begin
                theta_rd   = 1'b1;
                theta_addr = AW'(int'(cls_cnt) * NFEAT + int'(feat_cnt));
                if (last_read) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: state_next = OUT;
            OUT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // feat_cnt is the write pointer while loading and the read index in RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            feat_cnt  <= '0;
            cls_cnt   <= '0;
            len_q     <= '0;
            len_err_q <= 1'b0;
        end else begin
            len_err_q <= 1'b0;
            if (end_beat) begin
                feat_cnt  <= '0;
                len_q     <= feat_cnt + 1'b1;
                // Error when x_last and "final index" disagree.
                len_err_q <= x_last ^ (feat_cnt == FW'(NFEAT - 1));
            end else if (beat) begin
                feat_cnt <= feat_cnt + 1'b1;
            end else if (state == RUN) begin
                if (feat_cnt == FW'(NFEAT - 1)) begin
                    feat_cnt <= '0;
                    cls_cnt  <= (cls_cnt == CW'(NCLASS - 1)) ? '0 : cls_cnt + 1'b1;
                end else begin
                    feat_cnt <= feat_cnt + 1'b1;
                end
            end
        end
    end

    // NOTE: the feature buffer is storage, not control, so it has no reset;
    // entries past the frame length are masked to zero on read instead.
    always_ff @(posedge clk) begin
        if (beat) begin
            fbuf[feat_cnt] <= x_data;
        end
        x_q <= (feat_cnt < len_q) ? fbuf[feat_cnt] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q   <= 1'b0;
            fidx_q <= '0;
            cls_q  <= '0;
        end else begin
            rd_q   <= theta_rd;
            fidx_q <= feat_cnt;
            cls_q  <= cls_cnt;
        end
    end

    logreg_mac_acc u_mac (
        .clk      (clk),
        .rst      (rst),
        .en       (rd_q),
        .first    (fidx_q == FW'(BIAS_IDX)),
        .zero     (fidx_q == FW'(ZERO_IDX)),
        .x        (x_q),
        .theta    (theta_data),
        .acc_next (acc_next)
    );

    // Compare against the class total as it lands, so the last class is
    // settled by the end of DRAIN. Strict > keeps the lowest index on ties.
    always_ff @(posedge clk) begin
        if (rst) begin
            best_score <= '0;
            best_class <= '0;
        end else if (rd_q && fidx_q == FW'(NFEAT - 1)) begin
            if (cls_q == '0 || $signed(acc_next) > $signed(best_score)) begin
                best_score <= acc_next;
                best_class <= cls_q;
            end
        end
    end

    assign res_class = best_class;
    assign res_score = best_score;
    assign len_err   = len_err_q;

endmodule

// File: tb/tb_logreg_mac_scheduler.sv
module tb_logreg_mac_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        x_valid;
    logic        x_ready;
    logic [31:0] x_data;
    logic        x_last;
    logic [7:0]  theta_addr;
    logic        theta_rd;
    logic [31:0] theta_data;
    logic        res_valid;
    logic        res_ready;
    logic [1:0]  res_class;
    logic [31:0] res_score;
    logic        len_err;
    logic        busy;

    logreg_mac_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .x_valid    (x_valid),
        .x_ready    (x_ready),
        .x_data     (x_data),
        .x_last     (x_last),
        .theta_addr (theta_addr),
        .theta_rd   (theta_rd),
        .theta_data (theta_data),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_class  (res_class),
        .res_score  (res_score),
        .len_err    (len_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int rd_cnt   = 0;
    int err_cnt  = 0;
    int mark     = 0;
    int rd_base  = 0;
    int err_base = 0;

    logic [31:0] rom [0:163];
    logic [31:0] xv  [0:40];

    // Theta ROM model; returns junk when not read so stale data is visible.
    always @(posedge clk) begin
        cyc        <= cyc + 1;
        theta_data <= theta_rd ? rom[theta_addr] : 32'hDEAD_BEEF;
    end

    always @(negedge clk) begin
        if (theta_rd) rd_cnt <= rd_cnt + 1;
        if (len_err)  err_cnt <= err_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h (%0d) exp=0x%08h (%0d)", tag, got, $signed(got), exp, $signed(exp));
        end
    endtask

    task automatic set_class(input int k, input logic [31:0] bias, input logic [31:0] rest);
        rom[k*41] = bias;
        for (int i = 1; i < 41; i++) rom[k*41 + i] = rest;
    endtask

    task automatic fill_x(input logic [31:0] v);
        for (int i = 0; i < 41; i++) xv[i] = v;
    endtask

    // Called just after a negedge; drives n beats, one per cycle.
    task automatic send(input int n, input bit last_flag);
        rd_base  = rd_cnt;
        err_base = err_cnt;
        for (int b = 0; b < n; b++) begin
            x_valid = 1'b1;
            x_data  = xv[b];
            x_last  = (b == n - 1) && last_flag;
            if (b == n - 1) mark = cyc;
            @(negedge clk);
        end
        x_valid = 1'b0;
        x_last  = 1'b0;
    endtask

    task automatic get_result(input string tag, input logic [1:0] ec, input logic [31:0] es,
                              input int exp_err, input int stall);
        int waited = 0;
        int bad    = 0;
        while (!res_valid && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_valid"},   res_valid, 1);
        check({tag, "_latency"}, cyc - mark, 166);
        check({tag, "_class"},   res_class, ec);
        check({tag, "_score"},   res_score, es);
        check({tag, "_reads"},   rd_cnt - rd_base, 164);
        check({tag, "_len_err"}, err_cnt - err_base, exp_err);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            if (res_valid !== 1'b1 || res_class !== ec || res_score !== es || x_ready !== 1'b0) bad++;
        end
        if (stall > 0) check({tag, "_stall_stable"}, bad, 0);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check({tag, "_idle_xready"}, x_ready, 1);
        check({tag, "_idle_rvalid"}, res_valid, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int waited;
        int seen;
        rst = 1'b1; x_valid = 1'b0; x_data = '0; x_last = 1'b0; res_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("rst_x_ready",    x_ready, 1);
        check("rst_theta_rd",   theta_rd, 0);
        check("rst_theta_addr", theta_addr, 0);
        check("rst_res_valid",  res_valid, 0);
        check("rst_res_class",  res_class, 0);
        check("rst_res_score",  res_score, 0);
        check("rst_len_err",    len_err, 0);
        check("rst_busy",       busy, 0);

        // Class k scores k + 39 -> class 3, 42.
        for (int k = 0; k < 4; k++) set_class(k, k, 1);
        fill_x(1);
        send(41, 1);
        check("t1_busy", busy, 1);
        get_result("t1", 2'd3, 32'd42, 0, 0);

        // Identical thetas: 5 + 39*6 = 239 for every class, tie -> class 0.
        for (int k = 0; k < 4; k++) set_class(k, 5, 2);
        fill_x(3);
        send(41, 1);
        get_result("t2_tie", 2'd0, 32'd239, 0, 0);

        // Short frame: 10 beats x[i]=i; buffer still holds 3s from before.
        // Score_k = t_k * (2+..+9) = 44*t_k, t = {1,3,2,-1} -> class 1, 132.
        set_class(0, 0, 1);
        set_class(1, 0, 3);
        set_class(2, 0, 2);
        set_class(3, 0, 32'hFFFF_FFFF);
        for (int i = 0; i < 10; i++) xv[i] = i;
        send(10, 1);
        get_result("t4_short", 2'd1, 32'd132, 1, 0);

        // All-negative scores: -100, -50, -7800, -7800 -> class 1, -50.
        set_class(0, 32'hFFFF_FF9C, 0);
        set_class(1, 32'hFFFF_FFCE, 0);
        set_class(2, 32'hFFFF_FF38, 32'hFFFF_FF38);
        set_class(3, 32'hFFFF_FF38, 32'hFFFF_FF38);
        fill_x(1);
        xv[2] = 32'h8000_0000;
        send(41, 1);
        get_result("t3_signed", 2'd1, 32'hFFFF_FFCE, 0, 0);

        // 0x80000000*2 wraps to 0; other classes land at 0x80000000.
        // Final beat lacks x_last: error pulse, frame still ends.
        set_class(0, 7, 2);
        for (int k = 1; k < 4; k++) set_class(k, 0, 1);
        fill_x(0);
        xv[2] = 32'h8000_0000;
        send(41, 0);
        get_result("t3_wrap", 2'd0, 32'd7, 1, 0);

        // Stalled output: identical thetas again, held 20 cycles.
        for (int k = 0; k < 4; k++) set_class(k, 5, 2);
        fill_x(3);
        send(41, 1);
        get_result("t5_stall", 2'd0, 32'd239, 0, 20);

        // Reset during class 2 of RUN.
        for (int k = 0; k < 4; k++) set_class(k, k, 1);
        fill_x(1);
        send(41, 1);
        waited = 0;
        while (!(theta_rd && theta_addr >= 8'd82) && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        check("t6_reached_class2", theta_addr >= 8'd82, 1);
        rst = 1'b1;
        @(negedge clk);
        check("t6_abort_busy",     busy, 0);
        check("t6_abort_theta_rd", theta_rd, 0);
        check("t6_abort_x_ready",  x_ready, 1);
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 200; c++) begin
            if (res_valid) seen++;
            @(negedge clk);
        end
        check("t6_no_res_valid", seen, 0);
        send(41, 1);
        get_result("t6_after_rst", 2'd3, 32'd42, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
